add_pipe_ctrl: RTL

ADD_PIPE_CTRL -- requirements
Module: add_pipe_ctrl

---
 rtl/add_pipe_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/add_pipe_ctrl.sv
// Two-stage add/subtract pipeline controller that drives an external 32-bit adder.
// S1 holds the operands and op; S2 holds the registered sum and flags.
module add_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_op,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_c,
    output logic        out_v,
    output logic        out_z,
    output logic        out_n
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    op_e          s1_op;
    logic         carry_q;

    logic         s2_load;
    logic         accept;
    logic         ovf;

    // Handshake, adder operand steering and overflow detection
    always_comb begin
        s2_load  = s1_valid && (!out_valid || out_ready) && !flush;
        in_ready = !flush && (!s1_valid || s2_load);
        accept   = in_valid && in_ready;
        add_a    = s1_a;
        add_b    = s1_b;
        add_cin  = 1'b0;
        case (s1_op)
            OP_ADD: begin
                add_cin = 1'b0;
            end
            OP_SUB: begin
                add_b   = ~s1_b;
                add_cin = 1'b1;
            end
            OP_ADC: begin
                add_cin = carry_q;
            end
            OP_SBC: begin
                add_b   = ~s1_b;
                add_cin = carry_q;
            end
            default: begin
                add_cin = 1'b0;
            end
        endcase
        ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    end

    // S1: operand stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= op_e'(in_op);
            end
        end
    end

    // S2: result stage; carry_q tracks the most recently completed op and survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_c      <= 1'b0;
            out_v      <= 1'b0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_load) begin
                out_result <= add_sum;
                out_c      <= add_cout;
                out_v      <= ovf;
                out_z      <= (add_sum == '0);
                out_n      <= add_sum[W-1];
                carry_q    <= add_cout;
            end
        end
    end

endmodule
